// File: rtl/board_ctrl.sv
// Tic-tac-toe board responder: samples move strobes, validates and commits moves,
// detects win/draw and hands bus ownership back through turn.
//
// state     | meaning
// WAIT_MOVE | idle, waiting for a submit rising edge from the active mover
// CHECK     | one cycle: evaluate lines on the freshly written board
// OVER      | game finished; only a restart submit is accepted
module board_ctrl #(
    parameter bit PLAYER_FIRST = 1'b1,
    parameter int LOC_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LOC_W-1:0] update_loc,
    input  logic             submit,
    input  logic             reset,
    output logic             turn,
    output logic [17:0]      cells,
    output logic [3:0]       move_count,
    output logic             game_over,
    output logic [1:0]       winner,
    output logic             illegal
);

    typedef enum logic [1:0] {
        WAIT_MOVE = 2'd0,
        CHECK     = 2'd1,
        OVER      = 2'd2
    } state_t;

    localparam logic TURN_RESET = ~PLAYER_FIRST;

    state_t      state_q, state_d;
    logic [17:0] cells_q, cells_d;
    logic [3:0]  move_count_q, move_count_d;
    logic        turn_q, turn_d;
    logic        game_over_q, game_over_d;
    logic [1:0]  winner_q, winner_d;
    logic        illegal_q, illegal_d;
    logic        submit_q;

    logic        submit_s;
    logic        sub_ev;
    logic        loc_ok;
    logic [3:0]  loc_idx;
    logic [1:0]  mover;

    assign submit_s = (submit === 1'b1);
    assign sub_ev   = submit_s & ~submit_q;
    assign loc_ok   = (update_loc <= LOC_W'(8));
    assign loc_idx  = 4'(update_loc);
    assign mover    = turn_q ? 2'b10 : 2'b01;

    function automatic logic line_hit(input logic [17:0] b, input logic [1:0] code);
        logic [1:0] c [9];
        for (int i = 0; i < 9; i++) c[i] = b[2*i +: 2];
        return (c[0] == code && c[1] == code && c[2] == code) ||
               (c[3] == code && c[4] == code && c[5] == code) ||
               (c[6] == code && c[7] == code && c[8] == code) ||
               (c[0] == code && c[3] == code && c[6] == code) ||
               (c[1] == code && c[4] == code && c[7] == code) ||
               (c[2] == code && c[5] == code && c[8] == code) ||
               (c[0] == code && c[4] == code && c[8] == code) ||
               (c[2] == code && c[4] == code && c[6] == code);
    endfunction

    always_comb begin
        state_d      = state_q;
        cells_d      = cells_q;
        move_count_d = move_count_q;
        turn_d       = turn_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        illegal_d    = 1'b0;

        case (state_q)
            WAIT_MOVE: begin
                if (sub_ev) begin
                    if (reset) begin
                        cells_d      = '0;
                        move_count_d = '0;
                        winner_d     = 2'b00;
                        game_over_d  = 1'b0;
                        turn_d       = TURN_RESET;
                    end else if (!loc_ok || (cells_q[{loc_idx, 1'b0} +: 2] != 2'b00)) begin
                        illegal_d = 1'b1;
                    end else begin
                        cells_d[{loc_idx, 1'b0} +: 2] = mover;
                        move_count_d = move_count_q + 4'd1;
                        state_d      = CHECK;
                    end
                end
            end
            CHECK: begin
                // Edges arriving here are dropped; the mover keeps the bus on game end.
                if (line_hit(cells_q, mover)) begin
                    winner_d    = mover;
                    game_over_d = 1'b1;
                    state_d     = OVER;
                end else if (move_count_q == 4'd9) begin
                    winner_d    = 2'b11;
                    game_over_d = 1'b1;
                    state_d     = OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = WAIT_MOVE;
                end
            end
            OVER: begin
                if (sub_ev) begin
                    if (reset) begin
                        cells_d      = '0;
                        move_count_d = '0;
                        winner_d     = 2'b00;
                        game_over_d  = 1'b0;
                        turn_d       = TURN_RESET;
                        state_d      = WAIT_MOVE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_MOVE;
        endcase
    end

    always_ff @(posedge clk) begin
        // The edge register keeps tracking submit through rst, so a strobe held
        // high across rst release is not mistaken for a fresh move.
        submit_q <= submit_s;
        if (rst) begin
            state_q      <= WAIT_MOVE;
            cells_q      <= '0;
            move_count_q <= '0;
            turn_q       <= TURN_RESET;
            game_over_q  <= 1'b0;
            winner_q     <= 2'b00;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cells_q      <= cells_d;
            move_count_q <= move_count_d;
            turn_q       <= turn_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            illegal_q    <= illegal_d;
        end
    end

    assign turn       = turn_q;
    assign cells      = cells_q;
    assign move_count = move_count_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Bench for board_ctrl: table of moves with hand-derived board results fed through
// a scoreboard queue, plus sequences for held strobes and rst during CHECK.
module tb_board_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  update_loc;
    logic        submit;
    logic        reset;
    logic        turn;
    logic [17:0] cells;
    logic [3:0]  move_count;
    logic        game_over;
    logic [1:0]  winner;
    logic        illegal;

    always #5 clk = ~clk;

    board_ctrl #(.PLAYER_FIRST(1'b1), .LOC_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .update_loc (update_loc),
        .submit     (submit),
        .reset      (reset),
        .turn       (turn),
        .cells      (cells),
        .move_count (move_count),
        .game_over  (game_over),
        .winner     (winner),
        .illegal    (illegal)
    );

    typedef struct {
        logic [3:0]  loc;
        bit          rg;
        bit          ill;
        logic [17:0] cells;
        logic [3:0]  cnt;
        bit          turn;
        bit          over;
        logic [1:0]  win;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] bd(input string s);
        logic [17:0] r = '0;
        for (int i = 0; i < 9; i++) begin
            if (s[i] == "P") r[2*i +: 2] = 2'b01;
            else if (s[i] == "A") r[2*i +: 2] = 2'b10;
        end
        return r;
    endfunction

    function automatic vec_t mk(input int loc, input bit rg, input bit ill, input string b,
                                input int cnt, input bit t, input bit ov, input logic [1:0] w);
        vec_t v;
        v.loc = 4'(loc); v.rg = rg; v.ill = ill; v.cells = bd(b);
        v.cnt = 4'(cnt); v.turn = t; v.over = ov; v.win = w;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t cur;
        bit   prev_turn;

        //           loc rg ill board        cnt turn over win
        vecs.push_back(mk(2, 0, 0, "..P......", 1, 1, 0, 2'b00));
        vecs.push_back(mk(5, 1, 0, ".........", 0, 0, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, "P........", 1, 1, 0, 2'b00));
        vecs.push_back(mk(3, 0, 0, "P..A.....", 2, 0, 0, 2'b00));
        vecs.push_back(mk(1, 0, 0, "PP.A.....", 3, 1, 0, 2'b00));
        vecs.push_back(mk(4, 0, 0, "PP.AA....", 4, 0, 0, 2'b00));
        vecs.push_back(mk(2, 0, 0, "PPPAA....", 5, 0, 1, 2'b01));
        vecs.push_back(mk(7, 0, 1, "PPPAA....", 5, 0, 1, 2'b01));
        vecs.push_back(mk(8, 1, 0, ".........", 0, 0, 0, 2'b00));
        vecs.push_back(mk(4, 0, 0, "....P....", 1, 1, 0, 2'b00));
        vecs.push_back(mk(4, 0, 1, "....P....", 1, 1, 0, 2'b00));
        vecs.push_back(mk(9, 0, 1, "....P....", 1, 1, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, "A...P....", 2, 0, 0, 2'b00));
        vecs.push_back(mk(8, 1, 0, ".........", 0, 0, 0, 2'b00));
        vecs.push_back(mk(8, 0, 0, "........P", 1, 1, 0, 2'b00));
        vecs.push_back(mk(3, 1, 0, ".........", 0, 0, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, "P........", 1, 1, 0, 2'b00));
        vecs.push_back(mk(1, 0, 0, "PA.......", 2, 0, 0, 2'b00));
        vecs.push_back(mk(2, 0, 0, "PAP......", 3, 1, 0, 2'b00));
        vecs.push_back(mk(4, 0, 0, "PAP.A....", 4, 0, 0, 2'b00));
        vecs.push_back(mk(3, 0, 0, "PAPPA....", 5, 1, 0, 2'b00));
        vecs.push_back(mk(5, 0, 0, "PAPPAA...", 6, 0, 0, 2'b00));
        vecs.push_back(mk(7, 0, 0, "PAPPAA.P.", 7, 1, 0, 2'b00));
        vecs.push_back(mk(6, 0, 0, "PAPPAAAP.", 8, 0, 0, 2'b00));
        vecs.push_back(mk(8, 0, 0, "PAPPAAAPP", 9, 0, 1, 2'b11));
        vecs.push_back(mk(1, 0, 1, "PAPPAAAPP", 9, 0, 1, 2'b11));
        vecs.push_back(mk(0, 1, 0, ".........", 0, 0, 0, 2'b00));

        rst = 1'b1; submit = 1'b0; reset = 1'b0; update_loc = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_cells", 32'(cells), 32'h0);
        chk("rst_count", 32'(move_count), 32'h0);
        chk("rst_turn", 32'(turn), 32'h0);
        chk("rst_over", 32'(game_over), 32'h0);
        chk("rst_winner", 32'(winner), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        rst = 1'b0;
        prev_turn = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            update_loc = vecs[i].loc;
            reset      = vecs[i].rg;
            submit     = 1'b1;
            sb.push_back(vecs[i]);
            @(negedge clk);
            submit = 1'b0;
            reset  = 1'b0;
            cur = sb.pop_front();
            chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(cur.ill));
            chk($sformatf("v%0d_cells", i), 32'(cells), 32'(cur.cells));
            chk($sformatf("v%0d_count", i), 32'(move_count), 32'(cur.cnt));
            if (!cur.rg) chk($sformatf("v%0d_turn_early", i), 32'(turn), 32'(prev_turn));
            @(negedge clk);
            chk($sformatf("v%0d_turn", i), 32'(turn), 32'(cur.turn));
            chk($sformatf("v%0d_over", i), 32'(game_over), 32'(cur.over));
            chk($sformatf("v%0d_winner", i), 32'(winner), 32'(cur.win));
            chk($sformatf("v%0d_illegal_end", i), 32'(illegal), 32'h0);
            prev_turn = cur.turn;
        end

        // rst asserted while the board is in CHECK, submit held high throughout
        @(negedge clk);
        update_loc = 4'd4; submit = 1'b1;
        @(negedge clk);
        chk("pre_rst_cells", 32'(cells), 32'(bd("....P....")));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_cells", 32'(cells), 32'h0);
        chk("mid_rst_count", 32'(move_count), 32'h0);
        chk("mid_rst_turn", 32'(turn), 32'h0);
        chk("mid_rst_over", 32'(game_over), 32'h0);
        chk("mid_rst_winner", 32'(winner), 32'h0);
        chk("mid_rst_illegal", 32'(illegal), 32'h0);
        repeat (3) @(negedge clk);
        chk("held_after_rst_cells", 32'(cells), 32'h0);
        chk("held_after_rst_count", 32'(move_count), 32'h0);
        chk("held_after_rst_illegal", 32'(illegal), 32'h0);
        submit = 1'b0;
        @(negedge clk);
        update_loc = 4'd6; submit = 1'b1;
        @(negedge clk);
        chk("rearm_cells", 32'(cells), 32'(bd("......P..")));
        chk("rearm_count", 32'(move_count), 32'h1);

        // same strobe held for several more cycles is still a single move
        repeat (4) @(negedge clk);
        chk("hold_count", 32'(move_count), 32'h1);
        chk("hold_turn", 32'(turn), 32'h1);
        chk("hold_illegal", 32'(illegal), 32'h0);
        submit = 1'b0;
        @(negedge clk);
        update_loc = 4'd0; submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        chk("ai_after_hold_cells", 32'(cells), 32'(bd("A.....P..")));
        @(negedge clk);
        chk("ai_after_hold_turn", 32'(turn), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
